// File: rtl/led_pattern_gen.sv
// led_pattern_gen: bring-up LED pattern generator with three patterns (blink,
// chase, binary count). A synchronised, debounced push-button cycles through them.
module led_pattern_gen #(
  parameter int NUM_LEDS        = 4,
  parameter int TICK_DIV        = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int PCNT_W = $clog2(TICK_DIV);
  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int IDX_W  = $clog2(NUM_LEDS);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BINARY = 2'd2
  } mode_e;

  // Button conditioning
  logic              s1, s2;
  logic              deb, deb_q;
  logic [DCNT_W-1:0] dcnt;
  logic              press;

  // Pattern timing and step state
  mode_e               mode_q, mode_d;
  logic [PCNT_W-1:0]   pcnt;
  logic                phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_LEDS-1:0] bcnt_q, bcnt_d;
  logic [NUM_LEDS-1:0] led_d;

  // Two-flop synchroniser: the button is asynchronous to clk.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse s1/s2 into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // Debouncer: accept a new level only after it persists DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb  <= 1'b0;
      dcnt <= '0;
    end else if (s2 == deb) begin
      dcnt <= '0;
    end else if (dcnt == DCNT_LAST) begin
      deb  <= s2;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

  // Delayed debounced level, used to detect the rising edge (press).
  always_ff @(posedge clk) begin
    if (rst) deb_q <= 1'b0;
    else     deb_q <= deb;
  end

  // Only presses count; releases produce no event.
  assign press = deb & ~deb_q;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) mode_q <= MODE_BLINK;
    else     mode_q <= mode_d;
  end

  // Mode next-state: each press advances blink -> chase -> binary -> blink.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mode_d = mode_q;
    if (press) begin
      unique case (mode_q)
        MODE_BLINK: mode_d = MODE_CHASE;
        MODE_CHASE: mode_d = MODE_BINARY;
        default:    mode_d = MODE_BLINK;
      endcase
    end
  end

  assign mode = mode_q;

  // Step prescaler; a press restarts the step period from zero.
  always_ff @(posedge clk) begin
    if (rst || press)           pcnt <= '0;
    else if (pcnt == PCNT_LAST) pcnt <= '0;
    else                        pcnt <= pcnt + PCNT_W'(1);
  end

  // Tick decoded straight from the prescaler register.
  assign tick = (pcnt == PCNT_LAST);

  // Step state next values: a press clears everything and wins over a tick.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    if (press) begin
      phase_d = 1'b0;
      idx_d   = '0;
      bcnt_d  = '0;
    end else if (tick) begin
      phase_d = ~phase_q;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      bcnt_d  = bcnt_q + NUM_LEDS'(1);
    end
  end

  // Step state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      idx_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // LED pattern from the current mode and the step state being loaded, so a
  // step shows up one cycle after its tick and a new mode one cycle after it takes effect.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_BLINK:  led_d = {NUM_LEDS{phase_d}};
      MODE_CHASE:  led_d = NUM_LEDS'(1) << idx_d;
      MODE_BINARY: led_d = bcnt_d;
      default:     led_d = '0;
    endcase
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) leds <= '0;
    else     leds <= led_d;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a cycle-indexed reference model.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int DB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         button = 1'b0;
  logic [N-1:0] leds;
  logic [1:0]   mode;
  logic         tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: sync pipeline, debounce streak, mode, and the cycle at
  // which the step count last restarted (origin); patterns follow arithmetically.
  bit     m_s1, m_s2, m_deb, m_deb_q;
  int     m_run, m_mode, m_origin;
  logic [N-1:0] e_leds;
  logic [1:0]   e_mode;
  logic         e_tick;

  led_pattern_gen #(
    .NUM_LEDS(N),
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .leds(leds),
    .mode(mode),
    .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [N-1:0] pattern(int md, int steps);
    case (md)
      0:       return (steps % 2) ? 4'hF : 4'h0;
      1:       return 4'(1 << (steps % N));
      2:       return 4'(steps % 16);
      default: return 4'h0;
    endcase
  endfunction

  // Advance one clock edge, update the model, and land on the falling edge.
  task automatic step();
    int prev_mode;
    bit press_prev;
    bit nd;
    @(posedge clk);
    cyc++;
    prev_mode  = m_mode;
    press_prev = m_deb && !m_deb_q;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_q = 0;
      m_run = 0; m_mode = 0; m_origin = cyc;
      e_leds = '0;
    end else begin
      // The debounced level flips once the synced level has disagreed with it
      // for DB consecutive cycles.
      nd = m_deb;
      if (m_s2 != m_deb) begin
        if (m_run == DB - 1) begin
          nd = m_s2;
          m_run = 0;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      m_deb_q = m_deb;
      m_deb   = nd;
      m_s2    = m_s1;
      m_s1    = button;
      if (press_prev) begin
        m_mode   = (m_mode + 1) % 3;
        m_origin = cyc;
      end
      e_leds = pattern(prev_mode, (cyc - m_origin) / TD);
    end
    e_mode = 2'(m_mode);
    e_tick = ((cyc - m_origin) % TD) == TD - 1;
    @(negedge clk);
  endtask

  // Pure stimulus: hold the button at a level for n cycles.
  task automatic drive_button(bit level, int n);
    button = level;
    repeat (n) step();
  endtask

  task automatic test_reset();
    int base, r;
    rst = 1'b1;
    button = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if ({leds, mode, tick} !== 7'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d leds=%b mode=%0d tick=%b expected all zero", cyc, leds, mode, tick);
      end
    end
    base = cyc;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      r = cyc - base;
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
        errors++;
        $display("FAIL reset_model cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=%0d tick=%b", cyc, leds, mode, tick, e_leds, e_mode, e_tick);
      end
      checks++;
      if (tick !== (r == 3 || r == 7 || r == 11)) begin
        errors++;
        $display("FAIL reset_tick r=%0d tick=%b", r, tick);
      end
      if (r == 4 || r == 8 || r == 12) begin
        checks++;
        if (leds !== ((r == 8) ? 4'b0000 : 4'b1111) || mode !== 2'd0) begin
          errors++;
          $display("FAIL reset_blink r=%0d leds=%b mode=%0d", r, leds, mode);
        end
      end
    end
  endtask

  task automatic test_press_chase();
    int e_edge;
    rst = 1'b1; step(); rst = 1'b0;
    drive_button(1'b0, 5);
    button = 1'b1;
    step();
    e_edge = cyc;
    for (int i = 1; i < 70; i++) begin
      if (i == 30) button = 1'b0;
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
        errors++;
        $display("FAIL chase_model cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=%0d tick=%b", cyc, leds, mode, tick, e_leds, e_mode, e_tick);
      end
      if (cyc == e_edge + 9) begin
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL chase_early mode=%0d expected 0", mode); end
      end
      if (cyc == e_edge + 10) begin
        checks++;
        if (mode !== 2'd1) begin errors++; $display("FAIL chase_mode mode=%0d expected 1", mode); end
      end
      if (cyc == e_edge + 11) begin
        checks++;
        if (leds !== 4'b0001) begin errors++; $display("FAIL chase_first leds=%b expected 0001", leds); end
      end
      if (cyc == e_edge + 14 || cyc == e_edge + 18 || cyc == e_edge + 22 || cyc == e_edge + 26) begin
        checks++;
        if (leds !== 4'(1 << (((cyc - e_edge - 10) / 4) % 4)) || mode !== 2'd1) begin
          errors++;
          $display("FAIL chase_step cyc=%0d leds=%b mode=%0d", cyc, leds, mode);
        end
      end
    end
  endtask

  task automatic test_glitch();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      button = (i >= 6 && i < 11);
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick} || mode !== 2'd0) begin
        errors++;
        $display("FAIL glitch cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=0 tick=%b", cyc, leds, mode, tick, e_leds, e_tick);
      end
    end
  endtask

  task automatic test_two_presses();
    int e_edge;
    rst = 1'b1; step(); rst = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      drive_button(1'b1, 20);
      drive_button(1'b0, 20);
      checks++;
      if (mode !== 2'(p)) begin errors++; $display("FAIL press_count mode=%0d expected %0d", mode, p); end
    end
    for (int i = 0; i < 70; i++) begin
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
        errors++;
        $display("FAIL binary_model cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=%0d tick=%b", cyc, leds, mode, tick, e_leds, e_mode, e_tick);
      end
    end
    button = 1'b1;
    step();
    e_edge = cyc;
    for (int i = 1; i < 30; i++) begin
      if (i == 20) button = 1'b0;
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
        errors++;
        $display("FAIL third_model cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=%0d tick=%b", cyc, leds, mode, tick, e_leds, e_mode, e_tick);
      end
      if (cyc == e_edge + 11) begin
        checks++;
        if (mode !== 2'd0 || leds !== 4'b0000) begin
          errors++;
          $display("FAIL third_press mode=%0d leds=%b expected mode=0 leds=0000", mode, leds);
        end
      end
    end
  endtask

  task automatic test_press_on_tick();
    int e_edge;
    int guard;
    rst = 1'b1; step(); rst = 1'b0;
    drive_button(1'b0, 3);
    guard = 0;
    // Align so the press cycle (first sample + DB + 1) lands on a tick cycle.
    while (((cyc + 1 + DB + 1 - m_origin) % TD) != TD - 1 && guard < 2 * TD) begin
      step();
      guard++;
    end
    button = 1'b1;
    step();
    e_edge = cyc;
    for (int i = 1; i < 30; i++) begin
      if (i == 20) button = 1'b0;
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
        errors++;
        $display("FAIL ptick_model cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=%0d tick=%b", cyc, leds, mode, tick, e_leds, e_mode, e_tick);
      end
      if (cyc == e_edge + DB + 1) begin
        checks++;
        if (tick !== 1'b1 || mode !== 2'd0) begin errors++; $display("FAIL ptick_coincide tick=%b mode=%0d expected tick=1 mode=0", tick, mode); end
      end
      if (cyc >= e_edge + DB + 2 && cyc <= e_edge + DB + 5) begin
        checks++;
        if (tick !== (cyc == e_edge + DB + 5) || mode !== 2'd1) begin
          errors++;
          $display("FAIL ptick_restart cyc=%0d tick=%b mode=%0d", cyc - e_edge, tick, mode);
        end
      end
      if (cyc == e_edge + DB + 3) begin
        checks++;
        if (leds !== 4'b0001) begin errors++; $display("FAIL ptick_leds leds=%b expected 0001", leds); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    rst = 1'b1; step(); rst = 1'b0;
    drive_button(1'b1, 20);
    drive_button(1'b0, 20);
    drive_button(1'b1, 20);
    drive_button(1'b0, 20);
    guard = 0;
    while (((cyc - m_origin) % 64) != 16 && guard < 70) begin
      step();
      guard++;
    end
    button = 1'b1;
    repeat (6) step();
    checks++;
    if (leds !== 4'b0101 || mode !== 2'd2 || {leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
      errors++;
      $display("FAIL rmid_setup leds=%b mode=%0d expected leds=0101 mode=2", leds, mode);
    end
    rst = 1'b1;
    button = 1'b0;
    step();
    checks++;
    if (leds !== 4'b0000 || mode !== 2'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset leds=%b mode=%0d tick=%b expected 0000/0/0", leds, mode, tick);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick} || mode !== 2'd0) begin
        errors++;
        $display("FAIL rmid_after cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=0 tick=%b", cyc, leds, mode, tick, e_leds, e_tick);
      end
    end
  endtask

  task automatic test_random();
    int left;
    rst = 1'b1; step(); rst = 1'b0;
    left = 0;
    for (int i = 0; i < 900; i++) begin
      if (left == 0) begin
        button = $urandom_range(0, 1);
        left = $urandom_range(1, 22);
      end
      left--;
      rst = ($urandom_range(0, 99) < 2);
      step();
      checks++;
      if ({leds, mode, tick} !== {e_leds, e_mode, e_tick}) begin
        errors++;
        $display("FAIL random cyc=%0d leds=%b mode=%0d tick=%b expected leds=%b mode=%0d tick=%b", cyc, leds, mode, tick, e_leds, e_mode, e_tick);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_chase();
    test_glitch();
    test_two_presses();
    test_press_on_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for board bring-up designs: drives `NUM_LEDS` status LEDs from a single system clock with three selectable patterns (blink, chase, binary count). A push-button, synchronised and debounced internally, cycles through the patterns. It sits directly behind the board clock buffer and replaces the fixed single-LED counter blinker in new bring-up designs.

## Interface
- `NUM_LEDS`, 4, number of LED outputs; legal range 2..16.
- `TICK_DIV`, 12_500_000, clock cycles per pattern step; ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive cycles a new button level must persist before acceptance; ≥ 2.
- `clk`  input  1  system clock, already buffered (BUFG) by the instantiating top level.
- `rst`  input  1  reset: one clock, synchronous, active-high.
- `button`  input  1  raw push-button level, asynchronous to `clk`, active-high.
- `leds`  output  NUM_LEDS  registered LED drive, active-high.
- `mode`  output  2  current pattern: 0 blink, 1 chase, 2 binary; 3 never occurs.
- `tick`  output  1  high exactly one cycle per step period.

## Operation
- Synchroniser: two flops `s1`, `s2` on `button`, both reset to 0.
- Debouncer: level `deb` (reset 0) and counter `dcnt` (reset 0).
  - `s2 == deb`: `dcnt` ← 0.
  - `s2 != deb` and `dcnt == DEBOUNCE_CYCLES-1`: `deb` ← `s2`, `dcnt` ← 0.
  - Otherwise `dcnt` increments.
- Press: `press` = `deb & ~deb_q`, where `deb_q` is `deb` delayed one cycle (reset 0). Releases produce no event.
- Mode register: reset 0. On `press`, advances 0→1→2→0.
- Prescaler `pcnt`: reset 0, counts 0..TICK_DIV-1, then wraps to 0. `tick` = (`pcnt == TICK_DIV-1`), decoded from the register.
- Step state, all reset to 0: `phase` (1 bit), `idx` (0..NUM_LEDS-1), `bcnt` (NUM_LEDS bits).
  - On each `tick` without `press`: `phase` toggles; `idx` increments and wraps NUM_LEDS-1→0; `bcnt` increments modulo 2^NUM_LEDS.
- `leds` register, next value:
  - mode 0: all bits = `phase`.
  - mode 1: one-hot, bit `idx` set.
  - mode 2: `bcnt`.
- Mode change clears state: on `press`, `pcnt`, `phase`, `idx` and `bcnt` all ← 0.

## Timing
- Reset values: `leds` = 0, `mode` = 0, `tick` = 0. All internal state is 0. Reset applies at the next `clk` edge, including mid-pattern and mid-debounce.
- `tick` is first high in cycle TICK_DIV-1 after reset release and then every TICK_DIV cycles.
- `leds` reflects step state with one register stage. The new pattern is visible one cycle after the `tick` cycle.
- Press latency: if `button` is first sampled high at edge E and held, then:
  - `deb` rises at E+DEBOUNCE_CYCLES+1;
  - `mode` changes at E+DEBOUNCE_CYCLES+2;
  - `leds` show the new mode's step-0 pattern at E+DEBOUNCE_CYCLES+3.
- A button pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no `deb` change and no press.
- Press in the same cycle as `tick`: `press` wins. Step state clears and the tick's step update is dropped. `tick` is still observable high that cycle.
- Holding the button indefinitely yields exactly one press. A new press requires release, which must also be debounced.

## Test plan
Bench parameters for all scenarios: NUM_LEDS=4, TICK_DIV=4, DEBOUNCE_CYCLES=8.
- Reset 3 cycles, release, button low. Required: `tick` high at cycles 3, 7, 11; `leds` goes 0000→1111 at cycle 4, 1111→0000 at 8, 0000→1111 at 12; `mode` stays 0.
- Button high, held 30 cycles, first sampled at edge E. Required: `mode` = 1 at E+10; `leds` = 0001 at E+11; each subsequent tick steps 0010, 0100, 1000, 0001.
- Button glitch high for 5 cycles, then low. Required: `mode` unchanged, no `press`, `leds` pattern uninterrupted.
- Two clean presses, each held 20 cycles with 20 cycles low between them. Required: `mode` 0→1→2; in mode 2 `leds` counts 0000, 0001, … 1111, 0000 on successive ticks. A third press returns `mode` to 0 with `leds` = 0000.
- Press timed so `press` coincides with a `tick` cycle. Required: `mode` advances; `pcnt` = 0 the next cycle; the next `tick` occurs 4 cycles later; `leds` shows the step-0 pattern of the new mode.
- In mode 2 with `bcnt` = 0101 and `dcnt` mid-count, assert `rst` for 1 cycle. Required: next edge gives `leds` = 0000, `mode` = 0, `tick` = 0; the in-flight press is discarded.
